// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel-enable divider, h/v counters, sync and colour pins,
// plus per-frame and game-rate tick pulses.
module vga_timing_gen #(
  parameter int DIV       = 4,
  parameter int H_TOTAL   = 800,
  parameter int H_SYNC    = 96,
  parameter int H_START   = 144,
  parameter int H_END     = 783,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 2,
  parameter int V_START   = 35,
  parameter int V_END     = 514,
  parameter int FRAME_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb_out,
  output logic        frame_tick,
  output logic        game_tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DW-1:0] DIV_L = DW'(DIV - 1);
  localparam logic [FW-1:0] FD_L  = FW'(FRAME_DIV - 1);
  localparam logic [9:0]    HT_L  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VT_L  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_L  = 10'(H_SYNC);
  localparam logic [9:0]    VS_L  = 10'(V_SYNC);
  localparam logic [9:0]    HST_L = 10'(H_START);
  localparam logic [9:0]    HEN_L = 10'(H_END);
  localparam logic [9:0]    VST_L = 10'(V_START);
  localparam logic [9:0]    VEN_L = 10'(V_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;
  logic          ft_q, gt_q;
  logic          line_end;
  logic          frame_end;

  always_comb begin
    pix_en    = (div_q == DIV_L);
    line_end  = (h_q == HT_L);
    frame_end = pix_en && line_end && (v_q == VT_L);
    div_d     = pix_en ? '0 : div_q + 1'b1;
    h_d       = h_q;
    v_d       = v_q;
    fc_d      = fc_q;
    if (pix_en) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == VT_L) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    if (frame_end) begin
      fc_d = (fc_q == FD_L) ? '0 : fc_q + 1'b1;
    end
  end

  assign bright = (h_q >= HST_L) && (h_q <= HEN_L) &&
                  (v_q >= VST_L) && (v_q <= VEN_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fc_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
      ft_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      ft_q  <= frame_end;
      gt_q  <= frame_end && (fc_q == FD_L);
      // pins sample the pre-advance counters, so they trail by one pixel
      if (pix_en) begin
        hs_q  <= ~(h_q < HS_L);
        vs_q  <= ~(v_q < VS_L);
        rgb_q <= bright ? rgb_in : '0;
      end
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign rgb_out    = rgb_q;
  assign frame_tick = ft_q;
  assign game_tick  = gt_q;

endmodule
